// File: rtl/clock_switch_pkg.sv
// Shared types and defaults for the clock-mux select sequencer.
package clock_switch_pkg;

  localparam int unsigned DefSettleCycles  = 4;
  localparam int unsigned DefSwitchCycles  = 8;
  localparam int unsigned DefTimeoutCycles = 1024;
  localparam logic        DefResetSel      = 1'b0;

  typedef enum logic [2:0] {
    StIdle,
    StQuiesce,
    StPre,
    StSwitch,
    StRelease
  } clock_switch_state_e;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/clock_switch_cnt.sv
// Loadable down-counter with zero flag; holds at zero instead of wrapping.
module clock_switch_cnt #(
  parameter int unsigned Width = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [Width-1:0] r_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else if (load_i) begin
      r_cnt <= load_val_i;
    end else if (dec_i && (r_cnt != '0)) begin
      r_cnt <= r_cnt - Width'(1);
    end
  end

  assign zero_o = (r_cnt == '0);

endmodule

// File: rtl/clock_switch_seq.sv
// Sequences BUFGMUX select changes: quiesce, settle, switch, wait, release + ack.
// Optional quiesce timeout enabled by defining CLOCK_SWITCH_SEQ_TIMEOUT_EN.
module clock_switch_seq
  import clock_switch_pkg::*;
#(
  parameter int unsigned SettleCycles  = DefSettleCycles,
  parameter int unsigned SwitchCycles  = DefSwitchCycles,
  parameter int unsigned TimeoutCycles = DefTimeoutCycles,
  parameter logic        ResetSel      = DefResetSel
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic req_i,
  input  logic target_i,
  input  logic quiesce_ack_i,
  output logic sel_o,
  output logic hold_o,
  output logic busy_o,
  output logic ack_o,
  output logic err_o
);

  localparam int unsigned CntW = $clog2(max3(SettleCycles, SwitchCycles, TimeoutCycles) + 1);
  localparam logic [CntW-1:0] SettleLoad = CntW'(SettleCycles - 1);
  localparam logic [CntW-1:0] SwitchLoad = CntW'(SwitchCycles - 1);
`ifdef CLOCK_SWITCH_SEQ_TIMEOUT_EN
  localparam logic [CntW-1:0] TimeoutLoad = CntW'(TimeoutCycles - 1);
`endif

  clock_switch_state_e r_state, w_state_d;
  logic                r_sel, w_sel_d;
  logic                r_target, w_target_d;
  logic                w_load, w_dec, w_zero;
  logic [CntW-1:0]     w_load_val;
`ifdef CLOCK_SWITCH_SEQ_TIMEOUT_EN
  logic                r_err, w_err_d;
`endif

  clock_switch_cnt #(
    .Width(CntW)
  ) u_cnt (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (w_load),
    .load_val_i (w_load_val),
    .dec_i      (w_dec),
    .zero_o     (w_zero)
  );

  always_comb begin
    w_state_d  = r_state;
    w_sel_d    = r_sel;
    w_target_d = r_target;
    w_load     = 1'b0;
    w_load_val = '0;
    w_dec      = 1'b0;
`ifdef CLOCK_SWITCH_SEQ_TIMEOUT_EN
    w_err_d    = 1'b0;
`endif
    unique case (r_state)
      StIdle: begin
        if (req_i) begin
          if (target_i != r_sel) begin
            w_target_d = target_i;
            w_state_d  = StQuiesce;
`ifdef CLOCK_SWITCH_SEQ_TIMEOUT_EN
            w_load     = 1'b1;
            w_load_val = TimeoutLoad;
`endif
          end else begin
            // Already on the requested clock: acknowledge without disturbing anything
            w_state_d = StRelease;
          end
        end
      end
      StQuiesce: begin
        if (quiesce_ack_i) begin
          w_load     = 1'b1;
          w_load_val = SettleLoad;
          w_state_d  = StPre;
        end
`ifdef CLOCK_SWITCH_SEQ_TIMEOUT_EN
        else if (w_zero) begin
          w_err_d   = 1'b1;
          w_state_d = StRelease;
        end else begin
          w_dec = 1'b1;
        end
`endif
      end
      StPre: begin
        if (w_zero) begin
          w_sel_d    = r_target;
          w_load     = 1'b1;
          w_load_val = SwitchLoad;
          w_state_d  = StSwitch;
        end else begin
          w_dec = 1'b1;
        end
      end
      StSwitch: begin
        if (w_zero) begin
          w_state_d = StRelease;
        end else begin
          w_dec = 1'b1;
        end
      end
      StRelease: w_state_d = StIdle;
      default:   w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= StIdle;
      r_sel    <= ResetSel;
      r_target <= ResetSel;
    end else begin
      r_state  <= w_state_d;
      r_sel    <= w_sel_d;
      r_target <= w_target_d;
    end
  end

`ifdef CLOCK_SWITCH_SEQ_TIMEOUT_EN
  // High only during the RELEASE cycle that followed a timeout
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_err_d;
    end
  end
  assign err_o = r_err;
`else
  assign err_o = 1'b0;
`endif

  assign sel_o  = r_sel;
  assign busy_o = (r_state != StIdle);
  assign hold_o = (r_state == StQuiesce) || (r_state == StPre) || (r_state == StSwitch);
  assign ack_o  = (r_state == StRelease);

endmodule

// File: tb/tb_clock_switch_seq.sv
// Bench for clock_switch_seq: scenario table, hand-written corner cases, random vs model.
module tb_clock_switch_seq;

  localparam int S = 4;
  localparam int W = 8;
  localparam int T = 16;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic req_i = 1'b0;
  logic target_i = 1'b0;
  logic quiesce_ack_i = 1'b0;
  logic sel_o, hold_o, busy_o, ack_o, err_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  clock_switch_seq #(
    .SettleCycles  (S),
    .SwitchCycles  (W),
    .TimeoutCycles (T),
    .ResetSel      (1'b0)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .req_i         (req_i),
    .target_i      (target_i),
    .quiesce_ack_i (quiesce_ack_i),
    .sel_o         (sel_o),
    .hold_o        (hold_o),
    .busy_o        (busy_o),
    .ack_o         (ack_o),
    .err_o         (err_o)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    req_i = 1'b0;
    target_i = 1'b0;
    quiesce_ack_i = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  // One request at cycle 0; quiesce_ack rises at cycle 1+qdelay; optional stray requests.
  task automatic run_seq(input logic tgt, input int qdelay, input bit extra, input int maxc,
                         output int sel_cyc, output int ack_cyc, output int n_ack,
                         output int hold_cyc, output int err_cyc, output logic end_sel);
    logic prev_sel;
    do_reset();
    prev_sel = sel_o;
    sel_cyc = -1; ack_cyc = -1; n_ack = 0; hold_cyc = -1; err_cyc = -1;
    for (int c = 0; c < maxc; c++) begin
      if (sel_o !== prev_sel && sel_cyc < 0) sel_cyc = c;
      prev_sel = sel_o;
      if (ack_o === 1'b1) begin
        n_ack++;
        if (ack_cyc < 0) ack_cyc = c;
      end
      if (hold_o === 1'b1 && hold_cyc < 0) hold_cyc = c;
      if (err_o === 1'b1 && err_cyc < 0) err_cyc = c;
      req_i = (c == 0) || (extra && (c == 3 || c == 8));
      target_i = tgt;
      quiesce_ack_i = (c >= 1 + qdelay);
      @(posedge clk_i);
      @(negedge clk_i);
    end
    end_sel = sel_o;
    req_i = 1'b0;
  endtask

  // Timestamp-based reference model: tracks when each phase of a transaction starts/ends.
  int   m_cyc, m_req_cyc, m_sel_at, m_ack_at, m_err_at, m_busy_from;
  logic m_sel, m_new_sel;
  bit   m_wait;

  task automatic m_reset();
    m_cyc = 0; m_sel = 1'b0; m_new_sel = 1'b0; m_wait = 1'b0; m_req_cyc = 0;
    m_sel_at = -1; m_ack_at = -1; m_err_at = -1; m_busy_from = 0;
  endtask

  task automatic m_predict(output int exp);
    logic e_hold, e_busy, e_ack, e_err;
    if (m_cyc == m_sel_at) m_sel = m_new_sel;
    e_hold = m_wait || (m_cyc >= m_busy_from && m_cyc < m_ack_at);
    e_busy = m_wait || (m_cyc >= m_busy_from && m_cyc <= m_ack_at);
    e_ack  = (m_cyc == m_ack_at);
    e_err  = (m_cyc == m_err_at);
    exp = int'({m_sel, e_hold, e_busy, e_ack, e_err});
  endtask

  task automatic m_update(input logic req, input logic tgt, input logic q);
    int c;
    c = m_cyc;
    if (m_wait) begin
      if (q) begin
        m_wait = 1'b0;
        m_busy_from = c + 1;
        m_sel_at = c + 1 + S;
        m_ack_at = c + 1 + S + W;
      end
`ifdef CLOCK_SWITCH_SEQ_TIMEOUT_EN
      else if (c == m_req_cyc + T) begin
        m_wait = 1'b0;
        m_busy_from = c + 1;
        m_ack_at = c + 1;
        m_err_at = c + 1;
      end
`endif
    end else if (c > m_ack_at && req) begin
      if (tgt == m_sel) begin
        m_busy_from = c + 1;
        m_ack_at = c + 1;
      end else begin
        m_wait = 1'b1;
        m_req_cyc = c;
        m_new_sel = tgt;
      end
    end
    m_cyc++;
  endtask

  typedef struct {
    logic tgt;
    int   qdelay;
    bit   extra;
    int   exp_sel_cyc;
    int   exp_ack_cyc;
    int   exp_hold_cyc;
    logic exp_end_sel;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int   sc, ac, na, hc, ec, n, exp;
    logic es, q, rq, tg;

    vecs[0] = '{1'b1, 0,  1'b0, 6,  14, 1,  1'b1};
    vecs[1] = '{1'b0, 0,  1'b0, -1, 1,  -1, 1'b0};
    vecs[2] = '{1'b1, 10, 1'b0, 16, 24, 1,  1'b1};
    vecs[3] = '{1'b1, 0,  1'b1, 6,  14, 1,  1'b1};
    vecs[4] = '{1'b1, 3,  1'b1, 9,  17, 1,  1'b1};

    do_reset();
    check("reset_sel", int'(sel_o), 0);
    check("reset_flags", int'({hold_o, busy_o, ack_o, err_o}), 0);

    for (int i = 0; i < 5; i++) begin
      run_seq(vecs[i].tgt, vecs[i].qdelay, vecs[i].extra, 40, sc, ac, na, hc, ec, es);
      check($sformatf("vec%0d_sel_cycle", i), sc, vecs[i].exp_sel_cyc);
      check($sformatf("vec%0d_ack_cycle", i), ac, vecs[i].exp_ack_cyc);
      check($sformatf("vec%0d_ack_count", i), na, 1);
      check($sformatf("vec%0d_hold_cycle", i), hc, vecs[i].exp_hold_cyc);
      check($sformatf("vec%0d_err_cycle", i), ec, -1);
      check($sformatf("vec%0d_end_sel", i), int'(es), int'(vecs[i].exp_end_sel));
    end

    // Asynchronous reset in the middle of SWITCH
    do_reset();
    target_i = 1'b1;
    quiesce_ack_i = 1'b1;
    req_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    req_i = 1'b0;
    repeat (7) begin
      @(posedge clk_i);
      @(negedge clk_i);
    end
    check("midrst_sel_before", int'(sel_o), 1);
    check("midrst_hold_before", int'(hold_o), 1);
    #2 rst_i = 1'b1;
    #1;
    check("midrst_sel", int'(sel_o), 0);
    check("midrst_flags", int'({hold_o, busy_o, ack_o, err_o}), 0);
    @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    n = 0;
    for (int c = 0; c < 20; c++) begin
      if (ack_o === 1'b1 || sel_o !== 1'b0) n++;
      @(posedge clk_i);
      @(negedge clk_i);
    end
    check("midrst_no_ack_no_sel", n, 0);

`ifdef CLOCK_SWITCH_SEQ_TIMEOUT_EN
    run_seq(1'b1, 100000, 1'b0, 30, sc, ac, na, hc, ec, es);
    check("timeout_ack_cycle", ac, T + 1);
    check("timeout_err_cycle", ec, T + 1);
    check("timeout_ack_count", na, 1);
    check("timeout_sel_cycle", sc, -1);
    check("timeout_end_sel", int'(es), 0);
`else
    run_seq(1'b1, 100000, 1'b0, 40, sc, ac, na, hc, ec, es);
    check("noack_ack_cycle", ac, -1);
    check("noack_hold_cycle", hc, 1);
    check("noack_still_holding", int'({hold_o, busy_o}), 3);
    check("noack_sel_cycle", sc, -1);
`endif

    // Random traffic against the model
    do_reset();
    m_reset();
    q = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      m_predict(exp);
      check($sformatf("rand_cycle%0d {sel,hold,busy,ack,err}", i),
            int'({sel_o, hold_o, busy_o, ack_o, err_o}), exp);
      rq = ($urandom_range(0, 3) == 0);
      tg = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) q = ~q;
      req_i = rq;
      target_i = tg;
      quiesce_ack_i = q;
      m_update(rq, tg, q);
      @(posedge clk_i);
      @(negedge clk_i);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
